// File: rtl/pipe_hazard_ctrl.sv
// Central hazard scheduler for the 5-stage pipeline: advance enables, squashes,
// EX operand forwarding selects, memory-wait/redirect sequencing and perf counters.
module pipe_hazard_ctrl #(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [4:0]       rs_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       dst_ex,
    input  logic [4:0]       dst_mem,
    input  logic [4:0]       dst_wb,
    input  logic             regwr_ex,
    input  logic             regwr_mem,
    input  logic             regwr_wb,
    input  logic             memrd_ex,
    input  logic             take_mem,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             pc_redirect,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        MEMWAIT    = 2'b01,
        REDIR_PEND = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             mem_stall;
    logic             redirect;
    logic             data_hazard;

    // True when register r (never $0) is read by the ID instruction.
    function automatic logic id_reads(input logic [4:0] r, input logic [4:0] a,
                                      input logic [4:0] b, input logic ua, input logic ub);
        return (r != 5'd0) && ((ua && (a == r)) || (ub && (b == r)));
    endfunction

    // Operand source for one EX register: MEM result wins over WB result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic wr_m, input logic [4:0] d_m,
                                           input logic wr_w, input logic [4:0] d_w);
        if (wr_m && (d_m != 5'd0) && (d_m == src))
            return 2'b10;
        else if (wr_w && (d_w != 5'd0) && (d_w == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        data_hazard = 1'b0;
        if (FWD_EN)
            data_hazard = memrd_ex && id_reads(dst_ex, rs_id, rt_id, use_rs_id, use_rt_id);
        else
            data_hazard = (regwr_ex  && id_reads(dst_ex,  rs_id, rt_id, use_rs_id, use_rt_id))
                       || (regwr_mem && id_reads(dst_mem, rs_id, rt_id, use_rs_id, use_rt_id))
                       || (regwr_wb  && id_reads(dst_wb,  rs_id, rt_id, use_rs_id, use_rt_id));
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN && !rst) begin
            fwd_a = fwd_sel(rs_ex, regwr_mem, dst_mem, regwr_wb, dst_wb);
            fwd_b = fwd_sel(rt_ex, regwr_mem, dst_mem, regwr_wb, dst_wb);
        end
    end

    // Next state and pipeline controls: memory freeze > redirect > data hazard.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        pc_redirect = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        mem_stall   = (state_q == RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;
        redirect    = (state_q == REDIR_PEND) || take_mem;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (state_q == RUN)
                state_d = take_mem ? REDIR_PEND : MEMWAIT;
        end else if (redirect) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
        end else begin
            state_d = RUN;
            if (data_hazard) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_en && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (pc_redirect && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: one forwarding instance (CNT_W=4) and one
// stall-only instance share the stimulus; a behavioural model predicts every cycle.
module tb_pipe_hazard_ctrl;

    typedef struct {
        bit rst;
        int rs_id, rt_id;
        bit use_rs, use_rt;
        int rs_ex, rt_ex;
        int dst_ex, dst_mem, dst_wb;
        bit wr_ex, wr_mem, wr_wb;
        bit memrd, take, req, ready;
    } stim_t;

    typedef struct {
        int en;   // {pc, ifid, idex, exmem, memwb}
        int fl;   // {ifid, idex, exmem}
        int red;
        int fa, fb, st, sc, fc;
    } exp_t;

    typedef struct {
        exp_t f;
        exp_t n;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs_id = '0, rt_id = '0, rs_ex = '0, rt_ex = '0;
    logic [4:0] dst_ex = '0, dst_mem = '0, dst_wb = '0;
    logic use_rs_id = 1'b0, use_rt_id = 1'b0;
    logic regwr_ex = 1'b0, regwr_mem = 1'b0, regwr_wb = 1'b0;
    logic memrd_ex = 1'b0, take_mem = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b1;

    logic pc_en_f, ifid_en_f, idex_en_f, exmem_en_f, memwb_en_f, pc_redirect_f;
    logic ifid_flush_f, idex_flush_f, exmem_flush_f;
    logic [1:0] fwd_a_f, fwd_b_f, state_f;
    logic [3:0] stall_cnt_f, flush_cnt_f;
    logic pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n, pc_redirect_n;
    logic ifid_flush_n, idex_flush_n, exmem_flush_n;
    logic [1:0] fwd_a_n, fwd_b_n, state_n;
    logic [15:0] stall_cnt_n, flush_cnt_n;

    int n_checks = 0;
    int n_fail   = 0;
    pair_t sbq[$];
    int m_st[2];
    int m_sc[2];
    int m_fc[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(4)) dut_f (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
        .regwr_ex(regwr_ex), .regwr_mem(regwr_mem), .regwr_wb(regwr_wb),
        .memrd_ex(memrd_ex), .take_mem(take_mem), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en_f), .ifid_en(ifid_en_f), .idex_en(idex_en_f), .exmem_en(exmem_en_f),
        .memwb_en(memwb_en_f), .pc_redirect(pc_redirect_f), .ifid_flush(ifid_flush_f),
        .idex_flush(idex_flush_f), .exmem_flush(exmem_flush_f), .fwd_a(fwd_a_f), .fwd_b(fwd_b_f),
        .state(state_f), .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f)
    );

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
        .regwr_ex(regwr_ex), .regwr_mem(regwr_mem), .regwr_wb(regwr_wb),
        .memrd_ex(memrd_ex), .take_mem(take_mem), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en_n), .ifid_en(ifid_en_n), .idex_en(idex_en_n), .exmem_en(exmem_en_n),
        .memwb_en(memwb_en_n), .pc_redirect(pc_redirect_n), .ifid_flush(ifid_flush_n),
        .idex_flush(idex_flush_n), .exmem_flush(exmem_flush_n), .fwd_a(fwd_a_n), .fwd_b(fwd_b_n),
        .state(state_n), .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n)
    );

    // Reference model: k selects the instance, fe = forwarding enabled, maxc = counter ceiling.
    function automatic exp_t model(int k, bit fe, int maxc, stim_t s);
        exp_t e;
        int dst[3];
        bit wr[3];
        int srcs[2];
        int fw[2];
        bit waiting, frz, redir, haz, pc_ok;
        dst  = '{s.dst_ex, s.dst_mem, s.dst_wb};
        wr   = '{s.wr_ex, s.wr_mem, s.wr_wb};
        srcs = '{s.rs_ex, s.rt_ex};
        if (s.rst) begin
            m_st[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            e = '{en: 0, fl: 7, red: 0, fa: 0, fb: 0, st: 0, sc: 0, fc: 0};
            return e;
        end
        e.st = m_st[k]; e.sc = m_sc[k]; e.fc = m_fc[k];
        waiting = (m_st[k] != 0);
        frz   = waiting ? !s.ready : (s.req && !s.ready);
        redir = !frz && (m_st[k] == 2 || s.take);
        haz = 0;
        for (int i = 0; i < 3; i++) begin
            bit producer;
            producer = fe ? (i == 0 && s.memrd) : wr[i];
            if (producer && dst[i] != 0 &&
                ((s.use_rs && s.rs_id == dst[i]) || (s.use_rt && s.rt_id == dst[i])))
                haz = 1;
        end
        haz   = haz && !frz && !redir;
        pc_ok = !frz && !haz;
        e.en  = (int'(pc_ok) << 4) | (int'(pc_ok) << 3) | (!frz ? 7 : 0);
        e.fl  = (int'(redir) << 2) | (int'(redir || haz) << 1) | int'(redir);
        e.red = int'(redir);
        for (int j = 0; j < 2; j++) begin
            fw[j] = 0;
            if (fe) begin
                if (wr[1] && dst[1] != 0 && dst[1] == srcs[j]) fw[j] = 2;
                else if (wr[2] && dst[2] != 0 && dst[2] == srcs[j]) fw[j] = 1;
            end
        end
        e.fa = fw[0]; e.fb = fw[1];
        if (frz) begin
            if (!waiting) m_st[k] = s.take ? 2 : 1;
        end else begin
            m_st[k] = 0;
        end
        if (!pc_ok && m_sc[k] < maxc) m_sc[k]++;
        if (redir && m_fc[k] < maxc) m_fc[k]++;
        return e;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst: 0, rs_id: 0, rt_id: 0, use_rs: 0, use_rt: 0, rs_ex: 0, rt_ex: 0,
              dst_ex: 0, dst_mem: 0, dst_wb: 0, wr_ex: 0, wr_mem: 0, wr_wb: 0,
              memrd: 0, take: 0, req: 0, ready: 1};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        pair_t p;
        @(posedge clk);
        #1;
        rst = s.rst;
        rs_id = 5'(s.rs_id); rt_id = 5'(s.rt_id);
        use_rs_id = s.use_rs; use_rt_id = s.use_rt;
        rs_ex = 5'(s.rs_ex); rt_ex = 5'(s.rt_ex);
        dst_ex = 5'(s.dst_ex); dst_mem = 5'(s.dst_mem); dst_wb = 5'(s.dst_wb);
        regwr_ex = s.wr_ex; regwr_mem = s.wr_mem; regwr_wb = s.wr_wb;
        memrd_ex = s.memrd; take_mem = s.take; dmem_req = s.req; dmem_ready = s.ready;
        p.f = model(0, 1'b1, 15, s);
        p.n = model(1, 1'b0, 65535, s);
        sbq.push_back(p);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUTs present a full set of controls; compare against the queue head.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            pair_t p;
            p = sbq.pop_front();
            chk("f.enables", int'({pc_en_f, ifid_en_f, idex_en_f, exmem_en_f, memwb_en_f}), p.f.en);
            chk("f.flushes", int'({ifid_flush_f, idex_flush_f, exmem_flush_f}), p.f.fl);
            chk("f.redirect", int'(pc_redirect_f), p.f.red);
            chk("f.fwd", int'({fwd_a_f, fwd_b_f}), p.f.fa * 4 + p.f.fb);
            chk("f.state", int'(state_f), p.f.st);
            chk("f.stall_cnt", int'(stall_cnt_f), p.f.sc);
            chk("f.flush_cnt", int'(flush_cnt_f), p.f.fc);
            chk("n.enables", int'({pc_en_n, ifid_en_n, idex_en_n, exmem_en_n, memwb_en_n}), p.n.en);
            chk("n.flushes", int'({ifid_flush_n, idex_flush_n, exmem_flush_n}), p.n.fl);
            chk("n.redirect", int'(pc_redirect_n), p.n.red);
            chk("n.fwd", int'({fwd_a_n, fwd_b_n}), p.n.fa * 4 + p.n.fb);
            chk("n.state", int'(state_n), p.n.st);
            chk("n.stall_cnt", int'(stall_cnt_n), p.n.sc);
            chk("n.flush_cnt", int'(flush_cnt_n), p.n.fc);
        end
    end

    initial begin
        stim_t s;
        m_st = '{0, 0}; m_sc = '{0, 0}; m_fc = '{0, 0};

        // Reset
        s = nop(); s.rst = 1;
        repeat (2) apply(s);

        // Forwarding: MEM over WB, WB only, then $0 never forwards
        s = nop(); s.wr_mem = 1; s.dst_mem = 3; s.wr_wb = 1; s.dst_wb = 3; s.rs_ex = 3; s.rt_ex = 3;
        apply(s);
        s.wr_mem = 0;
        apply(s);
        s.dst_mem = 0; s.dst_wb = 0; s.wr_mem = 1; s.rs_ex = 0; s.rt_ex = 0;
        apply(s);

        // Load-use: lw $5 in EX, add $6,$5,$1 in ID; then bubble in EX; then add in EX
        s = nop(); s.memrd = 1; s.wr_ex = 1; s.dst_ex = 5;
        s.use_rs = 1; s.use_rt = 1; s.rs_id = 5; s.rt_id = 1;
        apply(s);
        s = nop(); s.wr_mem = 1; s.dst_mem = 5; s.use_rs = 1; s.use_rt = 1; s.rs_id = 5; s.rt_id = 1;
        apply(s);
        s = nop(); s.wr_wb = 1; s.dst_wb = 5; s.rs_ex = 5; s.rt_ex = 1;
        apply(s);

        // Taken branch with a simultaneous load-use condition
        s = nop(); s.take = 1; s.memrd = 1; s.wr_ex = 1; s.dst_ex = 2; s.use_rs = 1; s.rs_id = 2;
        apply(s);
        apply(nop());

        // Memory wait of 3 cycles with a pending branch, redirect in the ready cycle
        s = nop(); s.req = 1; s.ready = 0; s.take = 1;
        repeat (3) apply(s);
        s.ready = 1;
        apply(s);
        apply(nop());

        // RAW on WB without forwarding
        s = nop(); s.wr_wb = 1; s.dst_wb = 7; s.use_rt = 1; s.rt_id = 7;
        apply(s);
        apply(nop());

        // Reset pulse in the middle of a memory wait
        s = nop(); s.req = 1; s.ready = 0;
        repeat (2) apply(s);
        s.rst = 1;
        apply(s);
        s.rst = 0; s.ready = 1;
        apply(s);
        apply(nop());

        // Long freeze: 4-bit stall counter saturates at 15
        s = nop(); s.req = 1; s.ready = 0;
        repeat (20) apply(s);
        s.ready = 1;
        apply(s);

        // Randomised traffic over a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            s = nop();
            s.rst    = ($urandom_range(0, 79) == 0);
            s.rs_id  = $urandom_range(0, 3); s.rt_id = $urandom_range(0, 3);
            s.use_rs = $urandom_range(0, 1); s.use_rt = $urandom_range(0, 1);
            s.rs_ex  = $urandom_range(0, 3); s.rt_ex = $urandom_range(0, 3);
            s.dst_ex = $urandom_range(0, 3); s.dst_mem = $urandom_range(0, 3);
            s.dst_wb = $urandom_range(0, 3);
            s.wr_ex  = $urandom_range(0, 1); s.wr_mem = $urandom_range(0, 1);
            s.wr_wb  = $urandom_range(0, 1);
            s.memrd  = ($urandom_range(0, 2) == 0);
            s.take   = ($urandom_range(0, 7) == 0);
            s.req    = ($urandom_range(0, 3) == 0);
            s.ready  = ($urandom_range(0, 2) != 0);
            apply(s);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard scheduler for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Decides every cycle which pipeline registers advance, which are bubbled or squashed, and where the EX operands come from.
- Replaces the ad-hoc stall and flush logic spread across the top level.
- Branch/jump resolution stays in MEM; data memory may take several cycles (ready handshake).
- Keeps saturating stall and flush counters for performance debug.

## Interface
- FWD_EN, 1, 1: use EX operand forwarding; 0: RAW hazards stall in ID until the producer has left WB.
- CNT_W, 16, width of the performance counters.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rs_id, rt_id  in  5 each  source registers of the ID instruction
- use_rs_id, use_rt_id  in  1 each  ID instruction reads rs / rt
- rs_ex, rt_ex  in  5 each  source registers of the EX instruction
- dst_ex, dst_mem, dst_wb  in  5 each  destination register per stage
- regwr_ex, regwr_mem, regwr_wb  in  1 each  stage writes the register file
- memrd_ex  in  1  EX instruction is a load
- take_mem  in  1  branch taken or jump in MEM (PC redirect request)
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register advance enables
- pc_redirect  out  1  PC loads the MEM-stage target instead of PC+4
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous squash to NOP on next edge
- fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result
- state  out  2  00 RUN, 01 MEMWAIT, 10 REDIR_PEND
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- Register 0 is never a hazard source: every comparison requires dst != 0.
- Forwarding (combinational, FWD_EN=1):
  - fwd_a=10 if regwr_mem && dst_mem==rs_ex.
  - Else fwd_a=01 if regwr_wb && dst_wb==rs_ex.
  - Else fwd_a=00.
  - fwd_b is the same using rt_ex. MEM has priority over WB.
  - With FWD_EN=0, fwd_a and fwd_b are forced to 00.
- Load-use hazard, FWD_EN=1: memrd_ex && dst_ex!=0 && a used ID source equals dst_ex.
- RAW hazard, FWD_EN=0: any of the EX/MEM/WB stages has regwr && dst matching a used ID source.
- Data hazard response:
  - pc_en=0, ifid_en=0, idex_flush=1 (bubble).
  - The other enables are 1.
  - Lasts exactly as many cycles as the condition holds.
- States:
  - RUN:
    - If dmem_req && !dmem_ready, go to MEMWAIT; this overrides everything. If take_mem is also 1, go to REDIR_PEND instead.
    - Else, if take_mem: pc_redirect=1, all three flushes=1, all enables=1, stay in RUN.
    - Else, apply the data hazard response, if any.
  - MEMWAIT:
    - All enables=0, all flushes=0.
    - Leave on dmem_ready: the cycle with dmem_ready=1 behaves as RUN without the memory stall, and the next state is RUN.
  - REDIR_PEND:
    - Same as MEMWAIT; take_mem is held by the frozen MEM register.
    - On dmem_ready, perform the redirect (pc_redirect=1, three flushes) and return to RUN.
- Priority: memory freeze > redirect > data hazard. The data hazard is ignored in the redirect cycle because ID is being squashed.
- stall_cnt increments on every cycle with pc_en=0. flush_cnt increments on every cycle with pc_redirect=1. Both hold at all-ones.

## Timing
- Outputs are combinational from the inputs and the registered state. State and counters update on the rising edge of clk.
- Reset (asynchronous assert, synchronous release on the first edge after deassert):
  - state=RUN, counters=0.
  - While rst=1: all enables=0, all flushes=1, pc_redirect=0, fwd=00.
- Load-use costs exactly 1 bubble. The dependent instruction then forwards from WB (fwd=01) in EX.
- A taken branch costs 3 squashed slots. The target is fetched in the cycle after pc_redirect.
- A memory access with N wait cycles (dmem_ready low for N cycles) freezes the pipeline for N cycles; state returns to RUN the cycle after ready.
- Reset asserted in MEMWAIT or REDIR_PEND aborts immediately; a pending redirect is discarded.

## Test plan
- Forwarding: add $3 in MEM, add $3 in WB, EX reads rs=$3 → fwd_a=10. Repeat with dst=$0 → fwd_a=00.
- Load-use: `lw $5` in EX, ID `add $6,$5,$1` → 1 cycle of pc_en=0, idex_flush=1; next cycle fwd_a=01; stall_cnt=1.
- Taken branch: take_mem=1 in RUN → pc_redirect=1, ifid/idex/exmem_flush=1 in one cycle; flush_cnt=1. A simultaneous load-use condition is ignored.
- Memory wait with branch: dmem_req=1, dmem_ready=0 for 3 cycles, take_mem=1 → state REDIR_PEND, enables 0 for 3 cycles; redirect in the ready cycle; stall_cnt=3.
- FWD_EN=0: regwr_wb=1, dst_wb=$7, ID uses rt=$7 → stall 1 cycle, fwd=00.
- Reset mid-MEMWAIT: rst pulse → state=00, counters 0, flushes 1 while rst=1; pipeline runs normally after release. Also drive stall_cnt to saturation with CNT_W=4 → stays 15.
